alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the core's combinational ALU. Accepts one operation at a time over a valid/ready interface, computes add/sub/logic/compare ops in one cycle, and executes shifts iteratively at SHIFT_STEP bits per cycle. The result is held in an output register until the consumer takes it. It sits in the execute stage between the operand-select mux and writeback, and replaces the combinational ALU on the integer path.

## Interface
- DATA_WIDTH, 32: operand and result width; must be at least 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH): width of the shift amount; 5 when DATA_WIDTH is 32.
- SHIFT_STEP, 1: bits shifted per cycle; a power of two, at most DATA_WIDTH.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block can accept an operation this cycle.
- operands_a_i  in  DATA_WIDTH  operand A; the shifted value for SLL/SRL/SRA.
- operands_b_i  in  DATA_WIDTH  operand B; bits [SHAMT_WIDTH-1:0] are the shift amount.
- alu_op_i  in  5  core_pkg op: ADD, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
- invert_i  in  1  ADD becomes SUB; ignored for all other ops.
- flush_i  in  1  synchronous abort of any in-flight or held operation.
- valid_o  out  1  result registers valid.
- ready_i  in  1  consumer takes the result.
- result_o  out  DATA_WIDTH  operation result.
- adder_o  out  DATA_WIDTH+1  {carry, sum} of A+B, or of A+~B+1 when invert_i is set; registered.
- comp_o  out  1  registered compare flag: the SLT/SLTU outcome; 0 for every other op.

## Operation
- FSM has three states: IDLE, SHIFT, DONE. The state resets to IDLE.
- Reset values: valid_o=0, result_o=0, adder_o=0, comp_o=0. ready_o reads 1 after reset.
- ready_o = (state==IDLE) | (state==DONE & ready_i).
- An operation is accepted when valid_i & ready_o are both high. On acceptance the block latches A, B, op, invert_i and shamt = B[SHAMT_WIDTH-1:0].
- Single-cycle ops go from acceptance straight to DONE with result_o, adder_o and comp_o loaded:
  - ADD computes A+B mod 2^DATA_WIDTH; SUB computes A-B.
  - AND, OR and XOR are bitwise.
  - SLT is a signed compare, SLTU an unsigned compare. result_o is the zero-extended compare bit, and comp_o equals the same bit.
- Shift ops with shamt==0 go straight to DONE with result_o=A.
- Shift ops with shamt>0 go to SHIFT with rem=shamt. Each cycle in SHIFT:
  - shift the working register by min(SHIFT_STEP, rem) and subtract that amount from rem;
  - move to DONE on the cycle in which rem reaches 0.
- Shift fill rules: SLL shifts left with zero fill. SRL shifts right with zero fill. SRA shifts right and fills with the A[DATA_WIDTH-1] captured at acceptance.
- For shifts, adder_o and comp_o are 0.
- Any op outside the list completes in one cycle with result_o=0, adder_o=0, comp_o=0.
- DONE holds all outputs stable while ready_i is low.
- In DONE with ready_i=1:
  - with a new acceptance, the block loads the new op in the same edge (back-to-back, no bubble);
  - without one, it returns to IDLE and valid_o drops.
- flush_i forces IDLE and valid_o=0 on the next edge from any state, and the result registers are left unchanged.
- flush_i has priority over acceptance: ready_o is still computed as above, but an operation presented in a flush cycle is discarded.
- When rst_ni is asserted mid-shift, the block returns to reset values immediately (asynchronously), with no partial result visible.

## Timing
- Latency is 1+k cycles from the accept edge to valid_o high, where k = ceil(shamt/SHIFT_STEP) for shifts and k=0 for all other ops.
- Throughput:
  - single-cycle ops sustain one per cycle when ready_i is held high;
  - shifts cost 1+k cycles each, and ready_o is low for the whole SHIFT state.
- DATA_WIDTH=32, SHIFT_STEP=1, shamt=31 gives 32 cycles. With SHIFT_STEP=8 it gives 5 cycles, performed as steps of 8, 8, 8, 7.
- Every output is driven from a register. No input-to-output combinational path exists except ready_i→ready_o.

## Test plan
- ADD with invert_i=1, A=5, B=7 → one cycle later valid_o=1, result_o=32'hFFFFFFFE, adder_o[32]=0. With ready_i held low, all three outputs stay stable for 3 cycles.
- SLT with A=32'hFFFFFFFF, B=1 → result_o=1, comp_o=1. SLTU with the same operands → result_o=0, comp_o=0.
- SRA with A=32'h80000000, B=31, SHIFT_STEP=1 → valid_o rises 32 cycles after acceptance, result_o=32'hFFFFFFFF, and ready_o is low throughout. Repeat with SHIFT_STEP=8 → 5 cycles, same result.
- Back-to-back: XOR (A=32'hF0F0F0F0, B=32'hFFFF0000), then AND (A=32'hFF, B=32'h0F), with ready_i=1 → valid_o high on 2 consecutive cycles with results 32'h0F0FF0F0 then 32'h0F.
- SLL with A=1, B=20 and flush_i pulsed on the 5th cycle of SHIFT → next edge IDLE, valid_o=0, ready_o=1. A following SLL with B=0 → result_o=A after 1 cycle.
- rst_ni low mid-shift → valid_o, result_o, adder_o and comp_o are 0 immediately. After release, the first accepted ADD completes with normal latency.

Source files
------------

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked integer ALU. Add/sub/logic/compare complete in
//               one cycle; shifts run iteratively at SHIFT_STEP bits per
//               cycle. Results are held in output registers until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
    parameter int SHIFT_STEP  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] operands_a_i,
    input  logic [DATA_WIDTH-1:0] operands_b_i,
    input  logic [4:0]            alu_op_i,
    input  logic                  invert_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH:0]   adder_o,
    output logic                  comp_o
);

    // Operation encoding shared with the core's op decoder
    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_AND  = 5'd1;
    localparam logic [4:0] c_OP_OR   = 5'd2;
    localparam logic [4:0] c_OP_XOR  = 5'd3;
    localparam logic [4:0] c_OP_SLL  = 5'd4;
    localparam logic [4:0] c_OP_SRL  = 5'd5;
    localparam logic [4:0] c_OP_SRA  = 5'd6;
    localparam logic [4:0] c_OP_SLT  = 5'd7;
    localparam logic [4:0] c_OP_SLTU = 5'd8;

    // One extra bit so a step equal to DATA_WIDTH is still representable
    localparam logic [SHAMT_WIDTH:0] c_STEP = (SHAMT_WIDTH+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [4:0]             r_op;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [SHAMT_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0]  r_result;
    logic [DATA_WIDTH:0]    r_adder;
    logic                   r_comp;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_step_en;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic                   w_is_shift;
    logic                   w_start_shift;
    logic [DATA_WIDTH-1:0]  w_b_eff;
    logic [DATA_WIDTH:0]    w_adder;
    logic                   w_slt;
    logic                   w_sltu;
    logic [DATA_WIDTH-1:0]  w_res;
    logic [DATA_WIDTH:0]    w_add;
    logic                   w_cmp;
    logic [SHAMT_WIDTH:0]   w_step;
    logic [SHAMT_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0]  w_work_next;

    // Handshake: a held result frees the block in the same cycle it is taken
    assign w_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & ready_i);
    assign w_accept = valid_i & w_ready;
    assign ready_o  = w_ready;
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;
    assign adder_o  = r_adder;
    assign comp_o   = r_comp;

    assign w_shamt       = operands_b_i[SHAMT_WIDTH-1:0];
    assign w_is_shift    = (alu_op_i == c_OP_SLL) | (alu_op_i == c_OP_SRL) |
                           (alu_op_i == c_OP_SRA);
    assign w_start_shift = w_is_shift & (w_shamt != '0);

    // Shared adder; invert turns it into A + ~B + 1
    assign w_b_eff = invert_i ? ~operands_b_i : operands_b_i;
    assign w_adder = {1'b0, operands_a_i} + {1'b0, w_b_eff} +
                     {{DATA_WIDTH{1'b0}}, invert_i};
    assign w_slt   = $signed(operands_a_i) < $signed(operands_b_i);
    assign w_sltu  = operands_a_i < operands_b_i;

    // Result of any operation that completes on the accept edge
    always_comb begin
        w_res = '0;
        w_add = '0;
        w_cmp = 1'b0;
        case (alu_op_i)
            c_OP_ADD: begin
                w_res = w_adder[DATA_WIDTH-1:0];
                w_add = w_adder;
            end
            c_OP_AND: begin
                w_res = operands_a_i & operands_b_i;
                w_add = w_adder;
            end
            c_OP_OR: begin
                w_res = operands_a_i | operands_b_i;
                w_add = w_adder;
            end
            c_OP_XOR: begin
                w_res = operands_a_i ^ operands_b_i;
                w_add = w_adder;
            end
            c_OP_SLT: begin
                w_res = {{(DATA_WIDTH-1){1'b0}}, w_slt};
                w_add = w_adder;
                w_cmp = w_slt;
            end
            c_OP_SLTU: begin
                w_res = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
                w_add = w_adder;
                w_cmp = w_sltu;
            end
            c_OP_SLL, c_OP_SRL, c_OP_SRA: begin
                // Only reached with a zero shift amount
                w_res = operands_a_i;
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    // Shift step: min(SHIFT_STEP, remaining) bits this cycle
    always_comb begin
        w_step = ({1'b0, r_rem} < c_STEP) ? {1'b0, r_rem} : c_STEP;
        w_rem_next = r_rem - w_step[SHAMT_WIDTH-1:0];
        case (r_op)
            c_OP_SLL: w_work_next = r_work << w_step;
            c_OP_SRL: w_work_next = r_work >> w_step;
            // MSB of the working value is still the sign captured at accept
            c_OP_SRA: w_work_next = DATA_WIDTH'($signed(r_work) >>> w_step);
            default:  w_work_next = r_work;
        endcase
    end

    // Next-state logic; flush overrides everything including acceptance
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step_en    = 1'b0;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        w_load       = 1'b1;
                        w_state_next = w_start_shift ? S_SHIFT : S_DONE;
                    end else if (r_state == S_DONE && ready_i) begin
                        w_state_next = S_IDLE;
                    end
                end
                S_SHIFT: begin
                    w_step_en = 1'b1;
                    if (w_rem_next == '0) begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: capture on accept, iterate shifts, publish on completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= '0;
            r_work   <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_adder  <= '0;
            r_comp   <= 1'b0;
        end else if (w_load) begin
            r_op <= alu_op_i;
            if (w_start_shift) begin
                r_work <= operands_a_i;
                r_rem  <= w_shamt;
            end else begin
                r_result <= w_res;
                r_adder  <= w_add;
                r_comp   <= w_cmp;
            end
        end else if (w_step_en) begin
            r_work <= w_work_next;
            r_rem  <= w_rem_next;
            if (w_rem_next == '0) begin
                r_result <= w_work_next;
                r_adder  <= '0;
                r_comp   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq (SHIFT_STEP=1 main instance,
//               SHIFT_STEP=8 secondary instance for the stepped shift).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_SRA  = 5'd6;
    localparam logic [4:0] OP_SLT  = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8;
    localparam logic [4:0] OP_BAD  = 5'd31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        inv = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] res;
    logic [32:0] add;
    logic        comp;

    logic        bv = 1'b0;
    logic [4:0]  bop = '0;
    logic [31:0] ba = '0;
    logic [31:0] bb = '0;
    logic        b_ready_o;
    logic        b_valid_o;
    logic [31:0] b_res;
    logic [32:0] b_add;
    logic        b_comp;

    typedef struct {
        logic [31:0] res;
        logic [32:0] add;
        logic        cmp;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   fresh = 1'b1;

    alu_seq #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .operands_a_i(a), .operands_b_i(b), .alu_op_i(op), .invert_i(inv),
        .flush_i(flush), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(res), .adder_o(add), .comp_o(comp)
    );

    alu_seq #(.DATA_WIDTH(32), .SHIFT_STEP(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(bv), .ready_o(b_ready_o),
        .operands_a_i(ba), .operands_b_i(bb), .alu_op_i(bop), .invert_i(1'b0),
        .flush_i(1'b0), .valid_o(b_valid_o), .ready_i(1'b1),
        .result_o(b_res), .adder_o(b_add), .comp_o(b_comp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: latency on each fresh result, values on each consumption
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid_o=1 with result %0h, expected no pending result", res);
                end else begin
                    if (fresh) chk("latency_cycle", 64'(cyc), 64'(q[0].due));
                    if (ready_i) begin
                        m_e = q.pop_front();
                        chk("result", 64'(res), 64'(m_e.res));
                        chk("adder", 64'(add), 64'(m_e.add));
                        chk("comp", 64'(comp), 64'(m_e.cmp));
                    end
                end
                fresh = ready_i;
            end else begin
                fresh = 1'b1;
            end
        end
    end

    // Present an op at posedge+1, wait for acceptance, optionally expect it
    task automatic issue(input logic [4:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic xi,
                         input logic [31:0] er, input logic [32:0] ea,
                         input logic ec, input int lat, input bit push);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        op = o; a = xa; b = xb; inv = xi; valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        inv = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, expected 1", n);
        end else if (push) begin
            q.push_back('{res: er, add: ea, cmp: ec, due: cyc + lat - 1});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lows;
        int e;
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", 64'(res), 64'd0);
        chk("rst_adder", 64'(add), 64'd0);
        chk("rst_comp", 64'(comp), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // SUB held with ready_i low for 3 cycles
        ready_i = 1'b0;
        issue(OP_ADD, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 33'h0FFFFFFFE, 1'b0, 1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 64'(valid_o), 64'd1);
            chk("hold_result", 64'(res), 64'hFFFFFFFE);
            chk("hold_adder", 64'(add), 64'h0FFFFFFFE);
            chk("hold_comp", 64'(comp), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;

        issue(OP_SLT,  32'hFFFFFFFF, 32'd1, 1'b0, 32'd1, 33'h100000000, 1'b1, 1, 1'b1);
        issue(OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 33'h100000000, 1'b0, 1, 1'b1);
        issue(OP_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 32'h0F0FF0F0, 33'h1F0EFF0F0, 1'b0, 1, 1'b1);
        issue(OP_AND,  32'h000000FF, 32'h0000000F, 1'b0, 32'h0000000F, 33'h00000010E, 1'b0, 1, 1'b1);
        issue(OP_ADD,  32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 33'h100000000, 1'b0, 1, 1'b1);
        issue(OP_OR,   32'h12340000, 32'h00005678, 1'b0, 32'h12345678, 33'h012345678, 1'b0, 1, 1'b1);
        issue(OP_BAD,  32'd5, 32'd7, 1'b0, 32'd0, 33'd0, 1'b0, 1, 1'b1);
        issue(OP_SRL,  32'h80000000, 32'd4, 1'b0, 32'h08000000, 33'd0, 1'b0, 5, 1'b1);
        issue(OP_SLL,  32'd3, 32'd33, 1'b0, 32'd6, 33'd0, 1'b0, 2, 1'b1);

        // Full-length arithmetic shift; ready_o low throughout SHIFT
        issue(OP_SRA,  32'h80000000, 32'd31, 1'b0, 32'hFFFFFFFF, 33'd0, 1'b0, 32, 1'b1);
        lows = 0;
        repeat (31) begin
            @(negedge clk);
            if (!ready_o) lows++;
        end
        chk("sra_ready_low", 64'(lows), 64'd31);
        cycles(3);

        // Flush in IDLE discards a presented op; result registers untouched
        op = OP_ADD; a = 32'd1; b = 32'd1; valid_i = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("flush_discard_valid", 64'(valid_o), 64'd0);
        chk("flush_discard_result", 64'(res), 64'hFFFFFFFF);
        @(posedge clk);
        #1;

        // Flush on the 5th SHIFT cycle of SLL by 20
        issue(OP_SLL, 32'd1, 32'd20, 1'b0, 32'd0, 33'd0, 1'b0, 0, 1'b0);
        cycles(4);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);
        chk("flush_result_kept", 64'(res), 64'hFFFFFFFF);
        @(posedge clk);
        #1;
        issue(OP_SLL, 32'd5, 32'd0, 1'b0, 32'd5, 33'd0, 1'b0, 1, 1'b1);
        issue(OP_ADD, 32'd7, 32'd8, 1'b0, 32'h0F, 33'h00000000F, 1'b0, 1, 1'b1);
        cycles(2);

        // Asynchronous reset in the middle of a shift
        issue(OP_SLL, 32'd1, 32'd31, 1'b0, 32'd0, 33'd0, 1'b0, 0, 1'b0);
        cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_result", 64'(res), 64'd0);
        chk("arst_adder", 64'(add), 64'd0);
        chk("arst_comp", 64'(comp), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);
        issue(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 33'h080000000, 1'b0, 1, 1'b1);
        cycles(2);

        // SHIFT_STEP=8 instance: SRA by 31 in 5 cycles (8,8,8,7)
        bop = OP_SRA; ba = 32'h80000000; bb = 32'd31; bv = 1'b1;
        @(negedge clk);
        chk("b_ready_idle", 64'(b_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bv = 1'b0;
        e = cyc;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b_valid_o) break;
            if (!b_ready_o) lows++;
        end
        chk("b_valid", 64'(b_valid_o), 64'd1);
        chk("b_latency", 64'(cyc - e + 1), 64'd5);
        chk("b_result", 64'(b_res), 64'hFFFFFFFF);
        chk("b_ready_low", 64'(lows), 64'd4);
        cycles(3);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
